// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bus bundle: Execute redirect, instruction-memory port and decode handshake.
// master = environment side (Execute / imem / decode); slave = fetch_queue_stage side.
interface fetch_queue_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            StallD;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            o_p_waitrequest;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;

  modport master (
    output PCSrcE, PCTargetE, StallD, imem_rdata, o_p_waitrequest,
    input  imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD
  );

  modport slave (
    input  PCSrcE, PCTargetE, StallD, imem_rdata, o_p_waitrequest,
    output imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction fetch with a DEPTH-entry prefetch queue.
// Owns the PC, fetches one word per cycle while there is room, honours memory
// wait states, and flushes queue plus in-flight fetch on an Execute redirect.
// Optional feature: define FETCH_BYPASS_EN to forward a fetch straight to decode
// when the queue is empty (zero-latency fetch-to-decode).
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  fetch_queue_stage_if.slave bus
);

  localparam int unsigned     PW       = $clog2(DEPTH);
  localparam int unsigned     CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc4_mem_q [DEPTH];

  logic empty_s, full_s, head_pop_s, req_s, fire_s;
  logic byp_s, valid_s, pop_s, enq_s, deq_s;

  // Handshake decode; the request uses a queue-only pop so it never loops through the bypass path.
  always_comb begin
    empty_s    = (count_q == {CW{1'b0}});
    full_s     = (count_q == CNT_FULL);
    head_pop_s = !empty_s && !bus.StallD && !bus.PCSrcE;
    req_s      = rst && !bus.PCSrcE && (!full_s || head_pop_s);
    fire_s     = req_s && !bus.o_p_waitrequest;
`ifdef FETCH_BYPASS_EN
    byp_s      = empty_s && fire_s;
`else
    byp_s      = 1'b0;
`endif
    valid_s    = !empty_s || byp_s;
    pop_s      = valid_s && !bus.StallD && !bus.PCSrcE;
    // A bypassed word that decode takes immediately never enters the queue.
    enq_s      = fire_s && !(byp_s && pop_s);
    deq_s      = pop_s && !empty_s;
  end

  // Next-state for PC, pointers and occupancy; redirect flushes everything.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.PCSrcE) begin
      pc_d     = bus.PCTargetE;
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (fire_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage: capture {instr, pc, pc+4} at the write pointer on enqueue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i]   <= {XLEN{1'b0}};
        pc_mem_q[i]  <= {XLEN{1'b0}};
        pc4_mem_q[i] <= {XLEN{1'b0}};
      end
    end else if (enq_s) begin
      instr_q[wr_ptr_q]   <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]  <= pc_q;
      pc4_mem_q[wr_ptr_q] <= pc_q + PC_STEP;
    end
  end

  // Decode-facing outputs straight from the queue head, the bypass path, or zero when empty.
  always_comb begin
    bus.imem_req  = req_s;
    bus.imem_addr = pc_q;
    bus.ValidD    = valid_s;
    if (!empty_s) begin
      bus.InstrD   = instr_q[rd_ptr_q];
      bus.PCD      = pc_mem_q[rd_ptr_q];
      bus.PCPlus4D = pc4_mem_q[rd_ptr_q];
    end else if (byp_s) begin
      bus.InstrD   = bus.imem_rdata;
      bus.PCD      = pc_q;
      bus.PCPlus4D = pc_q + PC_STEP;
    end else begin
      bus.InstrD   = {XLEN{1'b0}};
      bus.PCD      = {XLEN{1'b0}};
      bus.PCPlus4D = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: a transaction-level model predicts fetch
// requests and pushes each accepted fetch into an expected queue; a monitor pops
// and compares whenever decode consumes an entry.
module tb_fetch_queue_stage;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_stage_if #(.XLEN(XLEN)) bus();

  fetch_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy count and PC, derived from the handshake rules.
  int          m_cnt = 0;
  logic [31:0] m_pc  = RESET_PC;
  bit          m_hp, m_req, m_fire, m_vld, m_pop, m_enq, m_deq;

  always @(negedge clk) begin
    if (!rst) begin
      m_cnt = 0;
      m_pc  = RESET_PC;
      exp_q.delete();
    end else begin
      m_hp   = (m_cnt > 0) && !bus.StallD && !bus.PCSrcE;
      m_req  = !bus.PCSrcE && ((m_cnt < DEPTH) || m_hp);
      m_fire = m_req && !bus.o_p_waitrequest;
`ifdef FETCH_BYPASS_EN
      m_vld  = (m_cnt > 0) || m_fire;
`else
      m_vld  = (m_cnt > 0);
`endif
      m_pop  = m_vld && !bus.StallD && !bus.PCSrcE;
      m_enq  = m_fire && !((m_cnt == 0) && m_pop);
      m_deq  = m_pop && (m_cnt > 0);
      chk("imem_req", 32'(bus.imem_req), 32'(m_req));
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("ValidD", 32'(bus.ValidD), 32'(m_vld));
      if (!m_vld) begin
        chk("PCD_empty", bus.PCD, 32'h0);
        chk("InstrD_empty", bus.InstrD, 32'h0);
        chk("PCPlus4D_empty", bus.PCPlus4D, 32'h0);
      end
      if (bus.PCSrcE) begin
        m_cnt = 0;
        m_pc  = bus.PCTargetE;
        exp_q.delete();
      end else begin
        if (m_fire) begin
          exp_q.push_back('{instr: mem_word(m_pc), pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
        m_cnt = m_cnt + int'(m_enq) - int'(m_deq);
      end
    end
  end

  // Monitor: every consumed decode entry must match the oldest expected fetch.
  ent_t e;
  always @(negedge clk) begin
    #1;
    if (rst && bus.ValidD && !bus.StallD && !bus.PCSrcE) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got PCD %h expected no entry at %0t", bus.PCD, $time);
      end else begin
        e = exp_q.pop_front();
        chk("PCD", bus.PCD, e.pc);
        chk("InstrD", bus.InstrD, e.instr);
        chk("PCPlus4D", bus.PCPlus4D, e.pc + 32'd4);
      end
    end
  end

  task automatic drive(input bit pcs, input logic [31:0] tgt, input bit st, input bit wt, input int n);
    for (int i = 0; i < n; i++) begin
      bus.PCSrcE          = pcs;
      bus.PCTargetE       = tgt;
      bus.StallD          = st;
      bus.o_p_waitrequest = wt;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      drive(($urandom_range(0, 19) == 0), {$urandom(), 2'b00} & 32'hFFFF_FFFC,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ValidD"}, 32'(bus.ValidD), 32'h0);
    chk({tag, "_imem_req"}, 32'(bus.imem_req), 32'h0);
    chk({tag, "_PCD"}, bus.PCD, 32'h0);
    chk({tag, "_InstrD"}, bus.InstrD, 32'h0);
    chk({tag, "_PCPlus4D"}, bus.PCPlus4D, 32'h0);
  endtask

  initial begin
    bus.PCSrcE          = 1'b0;
    bus.PCTargetE       = 32'h0;
    bus.StallD          = 1'b0;
    bus.o_p_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_imem_addr", bus.imem_addr, RESET_PC);
    rst = 1'b1;

    drive(1'b0, 32'h0, 1'b0, 1'b0, 20);          // free run
    drive(1'b0, 32'h0, 1'b1, 1'b0, 10);          // stall until full
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 3);           // memory wait states
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 6);           // fill, then redirect while stalled
    drive(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 8);
    drive(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1);   // PC wrap
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6);
    drive(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1);   // redirect beats stall and wait
    drive(1'b0, 32'h0, 1'b0, 1'b1, 2);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4);
    rand_run(400);

    // Reset asserted between clock edges while streaming.
    bus.PCSrcE          = 1'b0;
    bus.StallD          = 1'b1;
    bus.o_p_waitrequest = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    chk("midreset_imem_addr", bus.imem_addr, RESET_PC);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 10);
    rand_run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
